// File: rtl/line_buffer_window_3x3_module_if.sv
// Pixel stream in, packed 3x3 window out.
// Source side uses master, the window builder uses slave.
interface line_buffer_window_3x3_module_if;
  logic [11:0]  pixel_in;
  logic         pixel_valid;
  logic         frame_start;
  logic [107:0] color_data;
  logic         window_valid;

  modport master (
    output pixel_in,
    output pixel_valid,
    output frame_start,
    input  color_data,
    input  window_valid
  );

  modport slave (
    input  pixel_in,
    input  pixel_valid,
    input  frame_start,
    output color_data,
    output window_valid
  );
endinterface

// File: rtl/line_buffer_window_3x3_module.sv
// 3x3 RGB444 window builder: two line buffers plus a 3x3 tap register.
// Define SOBEL_WINDOW_ZERO_BORDER_EN for zero-padded border windows.
module line_buffer_window_3x3_module #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input logic clk,
  input logic reset,
  line_buffer_window_3x3_module_if.slave win_if
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic          accept;
  logic          restart;
  logic [CW-1:0] col_q;
  logic [CW-1:0] cur_col;
  logic [CW-1:0] col_next;
  logic [RW-1:0] row_q;
  logic [RW-1:0] cur_row;
  logic [RW-1:0] row_next;

  logic [11:0] lb1 [IMG_WIDTH];
  logic [11:0] lb2 [IMG_WIDTH];
  logic [11:0] rd1;
  logic [11:0] rd2;

  logic [11:0] taps_q [3][3];
  logic [11:0] taps_d [3][3];
  logic [11:0] win    [3][3];

  logic         emit;
  logic         mask_top;
  logic         mask_left;
  logic [107:0] win_packed;
  logic [107:0] color_q;
  logic         valid_q;

  assign accept  = win_if.pixel_valid;
  assign restart = accept & win_if.frame_start;

  // Coordinate of the pixel being accepted this cycle
  always_comb begin
    cur_col = restart ? '0 : col_q;
    cur_row = restart ? '0 : row_q;
  end

  always_comb begin
    col_next = cur_col + 1'b1;
    row_next = cur_row;
    if (cur_col == COL_LAST) begin
      col_next = '0;
      if (cur_row == ROW_LAST) begin
        row_next = '0;
      end else begin
        row_next = cur_row + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q <= '0;
      row_q <= '0;
    end else if (accept) begin
      col_q <= col_next;
      row_q <= row_next;
    end
  end

  // Line buffer RAM is deliberately left uninitialised
  assign rd1 = lb1[cur_col];
  assign rd2 = lb2[cur_col];

  always_ff @(posedge clk) begin
    if (accept) begin
      lb2[cur_col] <= rd1;
      lb1[cur_col] <= win_if.pixel_in;
    end
  end

  always_comb begin
    taps_d = taps_q;
    if (accept) begin
      for (int k = 0; k < 3; k++) begin
        taps_d[k][0] = taps_q[k][1];
        taps_d[k][1] = taps_q[k][2];
      end
      taps_d[0][2] = rd2;
      taps_d[1][2] = rd1;
      taps_d[2][2] = win_if.pixel_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 3; k++) begin
        for (int j = 0; j < 3; j++) begin
          taps_q[k][j] <= '0;
        end
      end
    end else begin
      taps_q <= taps_d;
    end
  end

`ifdef SOBEL_WINDOW_ZERO_BORDER_EN
  assign emit      = accept && (cur_row >= RW'(1)) && (cur_col >= CW'(1));
  assign mask_top  = (cur_row == RW'(1));
  assign mask_left = (cur_col == CW'(1));
`else
  assign emit      = accept && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
  assign mask_top  = 1'b0;
  assign mask_left = 1'b0;
`endif

  // Row -1 / column -1 taps read as black
  always_comb begin
    win = taps_d;
    if (mask_top) begin
      for (int j = 0; j < 3; j++) begin
        win[0][j] = 12'h000;
      end
    end
    if (mask_left) begin
      for (int k = 0; k < 3; k++) begin
        win[k][0] = 12'h000;
      end
    end
  end

  assign win_packed = {
    win[1][1], win[1][0], win[1][2],
    win[0][1], win[2][1],
    win[0][0], win[0][2],
    win[2][0], win[2][2]
  };

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      color_q <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= emit;
      if (emit) begin
        color_q <= win_packed;
      end
    end
  end

  assign win_if.color_data   = color_q;
  assign win_if.window_valid = valid_q;

endmodule

// File: tb/tb_line_buffer_window_3x3_module.sv
// Bench for the 3x3 window builder on a 4x4 image.
// Reference: an image array indexed by (row,col) with border rules.
module tb_line_buffer_window_3x3_module;

  localparam int W = 4;
  localparam int H = 4;
`ifdef SOBEL_WINDOW_ZERO_BORDER_EN
  localparam int LO = 1;
  localparam int NWIN = 9;
`else
  localparam int LO = 2;
  localparam int NWIN = 4;
`endif

  logic clk;
  logic reset;
  line_buffer_window_3x3_module_if bus ();

  line_buffer_window_3x3_module #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .win_if(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  logic [11:0]  img [0:H-1][0:W-1];
  int           mr;
  int           mc;
  int           acc_r;
  int           acc_c;
  logic [107:0] last;
  logic         exp_v;
  logic [107:0] exp_d;
  logic [107:0] ref_q [$];

  function automatic logic [11:0] px(input int rr, input int cc);
    if (rr < 0 || cc < 0) return 12'h000;
    return img[rr][cc];
  endfunction

  function automatic logic [107:0] window_at(input int r, input int c);
    return {px(r-1, c-1), px(r-1, c-2), px(r-1, c),
            px(r-2, c-1), px(r,   c-1),
            px(r-2, c-2), px(r-2, c),
            px(r,   c-2), px(r,   c)};
  endfunction

  task automatic drive(input logic v, input logic fs,
                       input logic [11:0] pix);
    int r;
    int c;
    @(negedge clk);
    bus.pixel_valid = v;
    bus.frame_start = fs;
    bus.pixel_in    = pix;
    exp_v = 1'b0;
    if (v) begin
      r = fs ? 0 : mr;
      c = fs ? 0 : mc;
      img[r][c] = pix;
      acc_r = r;
      acc_c = c;
      if (r >= LO && c >= LO) begin
        exp_v = 1'b1;
        last  = window_at(r, c);
      end
      mr = r;
      mc = c + 1;
      if (mc == W) begin
        mc = 0;
        mr = (r + 1 == H) ? 0 : r + 1;
      end
    end
    exp_d = last;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (bus.window_valid !== 1'b0 || bus.color_data !== 108'd0) begin
      failures++;
      $display("FAIL reset_hold valid=%b data=%h want 0/0",
               bus.window_valid, bus.color_data);
    end
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 1'b0, 12'h000);
    checks++;
    if (bus.window_valid !== 1'b0 || bus.color_data !== 108'd0) begin
      failures++;
      $display("FAIL reset_idle valid=%b data=%h want 0/0",
               bus.window_valid, bus.color_data);
    end
  endtask

  task automatic test_raster();
    int n;
    logic [11:0] p;
    n = 0;
    ref_q.delete();
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        p = {4'h0, r[3:0], c[3:0]};
        drive(1'b1, (r == 0 && c == 0), p);
        checks++;
        if (bus.window_valid !== exp_v || bus.color_data !== exp_d) begin
          failures++;
          $display("FAIL raster r=%0d c=%0d got %b/%h want %b/%h",
                   r, c, bus.window_valid, bus.color_data, exp_v, exp_d);
        end
        if (bus.window_valid === 1'b1) begin
          n++;
          ref_q.push_back(bus.color_data);
        end
`ifdef SOBEL_WINDOW_ZERO_BORDER_EN
        if (r == 1 && c == 1) begin
          checks++;
          if (n !== 1 || bus.window_valid !== 1'b1 ||
              bus.color_data[107:96] !== 12'h000 ||
              bus.color_data[83:72] !== 12'h001 ||
              bus.color_data[59:48] !== 12'h010 ||
              bus.color_data[11:0] !== 12'h011 ||
              bus.color_data[95:84] !== 12'h000 ||
              bus.color_data[71:60] !== 12'h000 ||
              bus.color_data[47:36] !== 12'h000 ||
              bus.color_data[35:24] !== 12'h000 ||
              bus.color_data[23:12] !== 12'h000) begin
            failures++;
            $display("FAIL zb_first n=%0d data=%h want %h",
                     n, bus.color_data,
                     {12'h000, 12'h000, 12'h001, 12'h000, 12'h010,
                      12'h000, 12'h000, 12'h000, 12'h011});
          end
        end
        if (r == 2 && c == 1) begin
          checks++;
          if (bus.color_data[95:84] !== 12'h000 ||
              bus.color_data[47:36] !== 12'h000 ||
              bus.color_data[23:12] !== 12'h000 ||
              bus.color_data[107:96] !== 12'h010) begin
            failures++;
            $display("FAIL zb_left data=%h want left col 0, centre 010",
                     bus.color_data);
          end
        end
`else
        if (r == 2 && c == 2) begin
          checks++;
          if (n !== 1 || bus.window_valid !== 1'b1 ||
              bus.color_data[107:96] !== 12'h011 ||
              bus.color_data[47:36] !== 12'h000 ||
              bus.color_data[11:0] !== 12'h022 ||
              bus.color_data[71:60] !== 12'h001 ||
              bus.color_data[95:84] !== 12'h010) begin
            failures++;
            $display("FAIL first_win n=%0d data=%h want c=011 ul=000 dr=022 u=001 l=010",
                     n, bus.color_data);
          end
        end
`endif
      end
    end
    checks++;
    if (n !== NWIN) begin
      failures++;
      $display("FAIL raster_count got %0d want %0d", n, NWIN);
    end
  endtask

  task automatic test_gaps();
    int n;
    logic [11:0] p;
    n = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        p = {4'h0, r[3:0], c[3:0]};
        drive(1'b0, 1'b0, 12'hfff);
        checks++;
        if (bus.window_valid !== 1'b0 || bus.color_data !== exp_d) begin
          failures++;
          $display("FAIL gap_idle r=%0d c=%0d got %b/%h want 0/%h",
                   r, c, bus.window_valid, bus.color_data, exp_d);
        end
        drive(1'b1, (r == 0 && c == 0), p);
        checks++;
        if (bus.window_valid !== exp_v || bus.color_data !== exp_d) begin
          failures++;
          $display("FAIL gap_acc r=%0d c=%0d got %b/%h want %b/%h",
                   r, c, bus.window_valid, bus.color_data, exp_v, exp_d);
        end
        if (bus.window_valid === 1'b1) begin
          checks++;
          if (n >= ref_q.size() || bus.color_data !== ref_q[n]) begin
            failures++;
            $display("FAIL gap_seq idx=%0d got %h want raster window",
                     n, bus.color_data);
          end
          n++;
        end
      end
    end
    checks++;
    if (n !== NWIN) begin
      failures++;
      $display("FAIL gap_count got %0d want %0d", n, NWIN);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, (i == 0), 12'($urandom));
      checks++;
      if (bus.window_valid !== exp_v || bus.color_data !== exp_d) begin
        failures++;
        $display("FAIL rst_f1 i=%0d got %b/%h want %b/%h",
                 i, bus.window_valid, bus.color_data, exp_v, exp_d);
      end
    end
    @(negedge clk);
    bus.pixel_valid = 1'b0;
    bus.frame_start = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.window_valid !== 1'b0 || bus.color_data !== 108'd0) begin
      failures++;
      $display("FAIL rst_async got %b/%h want 0/0",
               bus.window_valid, bus.color_data);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (bus.window_valid !== 1'b0 || bus.color_data !== 108'd0) begin
      failures++;
      $display("FAIL rst_held got %b/%h want 0/0",
               bus.window_valid, bus.color_data);
    end
    @(negedge clk);
    reset = 1'b0;
    mr = 0;
    mc = 0;
    last = '0;
    for (int i = 0; i < W * H; i++) begin
      drive(1'b1, 1'b0, 12'($urandom));
      checks++;
      if (bus.window_valid !== exp_v || bus.color_data !== exp_d) begin
        failures++;
        $display("FAIL rst_f2 r=%0d c=%0d got %b/%h want %b/%h",
                 acc_r, acc_c, bus.window_valid, bus.color_data,
                 exp_v, exp_d);
      end
    end
  endtask

  task automatic test_restart();
    int early;
    early = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, (i == 0), {4'h0, 4'(i / W), 4'(i % W)});
      if (bus.window_valid === 1'b1) early++;
    end
    drive(1'b1, 1'b1, 12'($urandom));
    if (bus.window_valid === 1'b1) early++;
    for (int i = 1; i < W * H; i++) begin
      drive(1'b1, 1'b0, 12'($urandom));
      if (acc_r < LO || (acc_r == LO && acc_c < LO)) begin
        if (bus.window_valid === 1'b1) early++;
      end
      checks++;
      if (bus.window_valid !== exp_v || bus.color_data !== exp_d) begin
        failures++;
        $display("FAIL restart r=%0d c=%0d got %b/%h want %b/%h",
                 acc_r, acc_c, bus.window_valid, bus.color_data,
                 exp_v, exp_d);
      end
    end
    checks++;
    if (early !== 0) begin
      failures++;
      $display("FAIL restart_early strobes=%0d want 0", early);
    end
  endtask

  task automatic test_fs_no_valid();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, (i == 0), 12'($urandom));
    end
    drive(1'b0, 1'b1, 12'($urandom));
    checks++;
    if (bus.window_valid !== 1'b0 || bus.color_data !== exp_d) begin
      failures++;
      $display("FAIL fs_idle got %b/%h want 0/%h",
               bus.window_valid, bus.color_data, exp_d);
    end
    for (int i = 6; i < 2 * W * H; i++) begin
      drive(1'b1, 1'b0, 12'($urandom));
      checks++;
      if (bus.window_valid !== exp_v || bus.color_data !== exp_d) begin
        failures++;
        $display("FAIL fs_cont r=%0d c=%0d got %b/%h want %b/%h",
                 acc_r, acc_c, bus.window_valid, bus.color_data,
                 exp_v, exp_d);
      end
    end
  endtask

  task automatic test_random();
    logic v;
    logic fs;
    for (int i = 0; i < 800; i++) begin
      v  = ($urandom_range(0, 3) != 0);
      fs = ($urandom_range(0, 47) == 0);
      drive(v, fs, 12'($urandom));
      checks++;
      if (bus.window_valid !== exp_v || bus.color_data !== exp_d) begin
        failures++;
        $display("FAIL random i=%0d got %b/%h want %b/%h",
                 i, bus.window_valid, bus.color_data, exp_v, exp_d);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    mr   = 0;
    mc   = 0;
    last = '0;
    reset = 1'b1;
    bus.pixel_in    = 12'h000;
    bus.pixel_valid = 1'b0;
    bus.frame_start = 1'b0;
    test_reset();
    test_raster();
    test_gaps();
    test_reset_mid();
    test_restart();
    test_fs_no_valid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/line_buffer_window_3x3_module.md
# line_buffer_window_3x3_module

Builds the 3x3 pixel neighbourhood consumed by the Sobel filter stages from a raster-order RGB444 pixel stream. Two internal line buffers and a 3x3 tap register turn each accepted pixel into a packed 108-bit window. The window feeds the `color_data` input of `sobel_edge_detect_X_filter_module`, and of its Y-direction sibling, directly.

## Interface
- `IMG_WIDTH`, 640: pixels per line, minimum 3.
- `IMG_HEIGHT`, 480: lines per frame, minimum 3.
- `clk` input 1: sole clock; everything is sampled on the rising edge.
- `reset` input 1: asynchronous, active-high.
- `pixel_in` input 12: RGB444 pixel, R=[11:8], G=[7:4], B=[3:0].
- `pixel_valid` input 1: `pixel_in` is accepted this cycle. There is no backpressure.
- `frame_start` input 1: qualified by `pixel_valid`; marks the accepted pixel as (row 0, col 0).
- `color_data` output 108: packed window.
- `window_valid` output 1: single-cycle strobe; `color_data` is a new window.

## Operation
- Counters `col` (0..IMG_WIDTH-1) and `row` (0..IMG_HEIGHT-1) give the coordinate (r,c) of each accepted pixel.
  - `col` wraps to 0 and increments `row`.
  - `row` wraps from IMG_HEIGHT-1 to 0.
  - `frame_start` with `pixel_valid` forces that pixel to (0,0), even mid-frame. Counters continue from there.
  - `frame_start` without `pixel_valid` is ignored.
- Line buffers:
  - LB1 holds row r-1 and LB2 holds row r-2.
  - Each is IMG_WIDTH x 12 bits, read and written at address `col`.
  - On an accept: LB2[col] <= LB1[col]; LB1[col] <= `pixel_in`.
- Tap register: on every accept, the 3x3 array shifts left one column. The new right column is (LB2[col], LB1[col], `pixel_in`).
- The window emitted for pixel (r,c) is centred at (r-1,c-1).
- Packing of `color_data`, with positions relative to the centre:
  - [107:96] centre, [95:84] left, [83:72] right
  - [71:60] up, [59:48] down
  - [47:36] upleft, [35:24] upright
  - [23:12] downleft, [11:0] downright
- Emission (default build): `window_valid` is asserted only for r>=2 and c>=2. This gives (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows per frame, with every tap inside the image.
- Cycles where `pixel_valid`=0:
  - no state changes;
  - `color_data` holds;
  - `window_valid`=0.
- Line buffer RAM is not cleared by reset or by `frame_start`. The emission and border rules guarantee that stale contents are never emitted.

## Timing
- Reset values: `color_data`=0 and `window_valid`=0; counters and the tap register are 0.
- Latency: the window for the pixel accepted in cycle N appears on `color_data`, with `window_valid`=1, in cycle N+1. Both outputs are registered.
- Throughput: one pixel per cycle sustained. Gaps in `pixel_valid` are arbitrary.
- Reset asserted mid-frame:
  - outputs clear immediately;
  - the next accepted pixel is (0,0), whether or not `frame_start` is set.
- Line wrap: taps carried over from the previous line, i.e. the columns shifted in at c=0 and c=1, never appear in an emitted default-build window. The rule c>=2 guarantees this.

## Configuration
- Macro `SOBEL_WINDOW_ZERO_BORDER_EN`.
- Undefined: interior-only emission, as described above.
- Defined:
  - `window_valid` is asserted for r>=1 and c>=1, giving (IMG_WIDTH-1)*(IMG_HEIGHT-1) windows per frame.
  - Taps at row -1 (when r==1) are forced to 12'h000.
  - Taps at column -1 (when c==1) are forced to 12'h000. This also prevents previous-line wrap data from appearing.
  - Latency is unchanged.

## Test plan
- Default build, 4x4 image, IMG_WIDTH=4 / IMG_HEIGHT=4, `pixel_in`=12'h0rc (value encodes row r and column c), `frame_start` on the first pixel, continuous `pixel_valid` -> exactly 4 strobes:
  - first strobe in the cycle after pixel (2,2);
  - its centre is 12'h011, upleft 12'h000, downright 12'h022, up 12'h001, left 12'h010.
- Same stimulus with `pixel_valid` toggling every other cycle -> identical window sequence; each strobe follows its accepting cycle by 1; `color_data` is stable between strobes.
- Zero-border build, 4x4 image, same stimulus -> 9 strobes:
  - the first follows pixel (1,1) with centre 12'h000, right 12'h001, down 12'h010, downright 12'h011, and all row -1 and column -1 taps 12'h000;
  - the window for pixel (2,1) has left/upleft/downleft = 12'h000.
- `reset` pulsed after pixel (2,3) of frame 1, then a second frame without `frame_start` -> outputs 0 during reset; the new frame's first strobe follows its pixel (2,2) and contains only frame-2 data.
- `frame_start` reasserted at pixel (1,2) of a 4x4 stream -> no strobe until the new (2,2); that window matches the reference window for a clean frame.
- `frame_start` high while `pixel_valid` low -> counters unchanged, no strobe.
